axis_file_driver: RTL and testbench
===================================

# axis_file_driver

Synthesizable-style AXI4-Stream master stage for the simulation bench. It sits directly downstream of the bench's file reader, which parses beat lines and time commands. It takes one parsed beat command at a time, waits either a relative delay or an absolute cycle time, then drives the beat onto the DUT's DMA or PHY AXI-Stream input, holding it stably until accepted. It also provides a free-running cycle counter, used as the bench timebase, and beat/packet statistics.

## Interface
- W_DATA, 512, stream data width in bits
- W_KEEP, W_DATA/8, byte-enable width
- W_DELAY, 32, width of the relative delay field
- clk  in  1  bench clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  parsed beat command available
- cmd_ready  out  1  driver accepts the command this cycle
- cmd_data  in  W_DATA  beat payload
- cmd_keep  in  W_KEEP  beat byte enables
- cmd_last  in  1  beat ends a packet
- cmd_abs  in  1  1: cmd_time is an absolute cycle; 0: cmd_time[W_DELAY-1:0] is a relative delay
- cmd_time  in  64  delay or target cycle
- cmd_eof  in  1  single-cycle pulse: reader has exhausted the file
- m_axis_tvalid / m_axis_tdata / m_axis_tkeep / m_axis_tlast  out  1/W_DATA/W_KEEP/1  stream to DUT
- m_axis_tready  in  1  DUT accepts
- cycle_count  out  64  cycles since reset deassertion
- beat_count  out  32  accepted beats
- pkt_count  out  32  accepted beats with tlast
- done  out  1  EOF seen and no beat pending

## Operation
- States: IDLE, WAIT_REL, WAIT_ABS, SEND.
- cmd_ready = (state==IDLE) | (state==SEND & m_axis_tready). This path is combinational from tready.
- On accept, the payload, keep, and last are captured into the output register.
  - cmd_abs=0 with delay 0: go to SEND.
  - cmd_abs=0 with delay D>0: load the down-counter with D-1 and go to WAIT_REL.
  - cmd_abs=1: go to WAIT_ABS.
- WAIT_REL: decrement each cycle; at 0, go to SEND.
- WAIT_ABS: go to SEND on the first cycle where cycle_count >= target. A target already in the past behaves as delay 0.
- SEND: tvalid=1. Data, keep, and last are stable until tready.
  - On handshake with no new command: go to IDLE.
  - On handshake with a simultaneous new command: process it as if accepted from IDLE.
- Statistics: beat_count += 1 on each handshake; pkt_count += 1 on handshake with tlast. Both wrap modulo 2^32.
- done: set when the eof flag is latched and state==IDLE and cmd_valid==0. Sticky until reset.
  - cmd_eof arriving in any state is latched.
  - A command arriving after eof is still processed, and done clears until IDLE again.
- cycle_count: increments every cycle after reset; wraps modulo 2^64, with no special handling.

## Timing
- Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, cycle_count=0, beat_count=0, pkt_count=0, done=0, state=IDLE.
- cmd_ready is 0 while rst is high.
- Reset asserted mid-beat drops tvalid immediately (asynchronously); the pending beat is discarded.
- Latency, command accepted at cycle N:
  - relative delay D: tvalid first high at N+1+D.
  - absolute target T: tvalid first high at max(N+1, first cycle with cycle_count==T).
- Back-to-back delay-0 commands give one beat per cycle under constant tready=1.
- tvalid never deasserts without a handshake. The driver never waits on tready before asserting tvalid.

## Structure
- Shared package `open_nic_drv_pkg` holds:
  - the state enum;
  - a packed beat-command struct (data, keep, last, abs, time);
  - W_DELAY.
- W_DATA and W_KEEP are taken from `open_nic_file_tools`.
- One sub-module is natural: `drv_delay_timer` (relative down-counter plus absolute comparator against cycle_count, with a single `expired` output).

## Test plan
- Three beats, delay 0, tready=1 → tvalid high for 3 consecutive cycles starting at N+1; beat_count=3; pkt_count=1 when the third beat has last=1.
- One beat, relative delay 5, accepted at N=10 → tvalid first high at cycle 16.
- Absolute target 100 accepted at cycle 20, plus a second command with target 50 accepted at cycle 101 → first beat appears at cycle_count==100; second beat appears at cycle 102.
- tready toggled 1-0-0-1 during SEND → tdata/tkeep/tlast unchanged while tvalid is high; exactly one handshake counted.
- Reset asserted while tvalid=1 with tdata=0xA5… → tvalid and all counters are 0 in the same cycle; no handshake counted.
- cmd_eof pulsed during WAIT_REL (delay 3) → done stays 0 until the beat is accepted and the driver is idle, then goes high and stays high.

Source files
------------

// File: rtl/open_nic_drv_pkg.sv
// Types shared by the AXI-Stream file driver and its delay timer.
package open_nic_drv_pkg;

  import open_nic_file_tools::*;

  localparam int unsigned W_DELAY = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRel,
    StWaitAbs,
    StSend
  } drv_state_e;

  typedef struct packed {
    logic [W_DATA-1:0] data;
    logic [W_KEEP-1:0] keep;
    logic              last;
    logic              is_abs;
    logic [63:0]       timing;
  } beat_cmd_t;

endpackage

// File: rtl/open_nic_file_tools.sv
// Bench-wide stream geometry shared by the file reader and its downstream stages.
package open_nic_file_tools;

  localparam int unsigned W_DATA = 512;
  localparam int unsigned W_KEEP = W_DATA / 8;

endpackage

// File: rtl/drv_delay_timer.sv
// Relative down-counter or absolute cycle target; expired means "send on the next cycle".
module drv_delay_timer
  import open_nic_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_abs,
  input  logic [63:0] load_time,
  input  logic [63:0] cycle_count,
  output logic        expired
);

  logic        abs_q;
  logic [63:0] cnt_q;

  // cnt_q holds either the remaining relative delay or the absolute target cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      abs_q <= load_abs;
      cnt_q <= load_abs ? load_time : 64'(load_time[W_DELAY-1:0]) - 64'd1;
    end else if (!abs_q && cnt_q != '0) begin
      cnt_q <= cnt_q - 64'd1;
    end
  end

  assign expired = abs_q ? (cycle_count + 64'd1 >= cnt_q) : (cnt_q == '0);

endmodule

// File: rtl/axis_file_driver.sv
// AXI4-Stream master stage: takes parsed beat commands, waits the requested time, drives the beat.
module axis_file_driver
  import open_nic_file_tools::*;
  import open_nic_drv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_DATA-1:0] cmd_data,
  input  logic [W_KEEP-1:0] cmd_keep,
  input  logic              cmd_last,
  input  logic              cmd_abs,
  input  logic [63:0]       cmd_time,
  input  logic              cmd_eof,
  output logic              m_axis_tvalid,
  output logic [W_DATA-1:0] m_axis_tdata,
  output logic [W_KEEP-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [63:0]       cycle_count,
  output logic [31:0]       beat_count,
  output logic [31:0]       pkt_count,
  output logic              done
);

  drv_state_e        state_q, state_d, route_st;
  beat_cmd_t         cmd;
  logic              accept, handshake, expired, timer_load;
  logic              eof_q, done_q, done_d;
  logic [63:0]       cycle_q;
  logic [31:0]       beat_q, pkt_q;
  logic [W_DATA-1:0] tdata_q;
  logic [W_KEEP-1:0] tkeep_q;
  logic              tlast_q;

  assign cmd = '{data: cmd_data, keep: cmd_keep, last: cmd_last, is_abs: cmd_abs,
                 timing: cmd_time};

  assign m_axis_tvalid = (state_q == StSend);
  assign handshake     = m_axis_tvalid & m_axis_tready;
  assign cmd_ready     = ~rst & ((state_q == StIdle) | handshake);
  assign accept        = cmd_valid & cmd_ready;

  always_comb begin
    // Where a freshly accepted command goes; a target that is already due sends at once.
    route_st = StSend;
    if (cmd.is_abs) begin
      if (cmd.timing > cycle_q + 64'd1) route_st = StWaitAbs;
    end else if (cmd.timing[W_DELAY-1:0] != '0) begin
      route_st = StWaitRel;
    end

    state_d = state_q;
    unique case (state_q)
      StIdle:               if (accept) state_d = route_st;
      StWaitRel, StWaitAbs: if (expired) state_d = StSend;
      StSend:               if (handshake) state_d = accept ? route_st : StIdle;
      default:              state_d = StIdle;
    endcase
  end

  assign timer_load = accept & (route_st != StSend);

  always_comb begin
    done_d = done_q;
    if (accept) begin
      done_d = 1'b0;
    end else if (eof_q && state_q == StIdle && !cmd_valid) begin
      done_d = 1'b1;
    end
  end

  drv_delay_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (timer_load),
    .load_abs    (cmd.is_abs),
    .load_time   (cmd.timing),
    .cycle_count (cycle_q),
    .expired     (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      cycle_q <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      eof_q   <= eof_q | cmd_eof;
      done_q  <= done_d;
      cycle_q <= cycle_q + 64'd1;
      if (handshake) beat_q <= beat_q + 32'd1;
      if (handshake && tlast_q) pkt_q <= pkt_q + 32'd1;
      if (accept) begin
        tdata_q <= cmd.data;
        tkeep_q <= cmd.keep;
        tlast_q <= cmd.last;
      end
    end
  end

  assign m_axis_tdata = tdata_q;
  assign m_axis_tkeep = tkeep_q;
  assign m_axis_tlast = tlast_q;
  assign cycle_count  = cycle_q;
  assign beat_count   = beat_q;
  assign pkt_count    = pkt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_axis_file_driver.sv
// Directed plus randomized bench for axis_file_driver, checked against a timing model of beats.
module tb_axis_file_driver;

  import open_nic_file_tools::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [W_DATA-1:0] cmd_data = '0;
  logic [W_KEEP-1:0] cmd_keep = '0;
  logic              cmd_last = 1'b0;
  logic              cmd_abs = 1'b0;
  logic [63:0]       cmd_time = '0;
  logic              cmd_eof = 1'b0;
  logic              m_axis_tvalid;
  logic [W_DATA-1:0] m_axis_tdata;
  logic [W_KEEP-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic [63:0]       cycle_count;
  logic [31:0]       beat_count;
  logic [31:0]       pkt_count;
  logic              done;

  int                checks = 0;
  int                failures = 0;
  int unsigned       exp_beats = 0;
  int unsigned       exp_pkts = 0;
  longint unsigned   cyc;

  axis_file_driver dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .cmd_keep      (cmd_keep),
    .cmd_last      (cmd_last),
    .cmd_abs       (cmd_abs),
    .cmd_time      (cmd_time),
    .cmd_eof       (cmd_eof),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .cycle_count   (cycle_count),
    .beat_count    (beat_count),
    .pkt_count     (pkt_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Bench timebase: at each falling edge cyc equals the cycle index since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [W_DATA-1:0] got,
                      input logic [W_DATA-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W_DATA-1:0] rnd_data();
    logic [W_DATA-1:0] v;
    for (int i = 0; i < W_DATA / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_cmd(input logic v, input logic a, input logic [63:0] t,
                         input logic [W_DATA-1:0] d, input logic [W_KEEP-1:0] k,
                         input logic l);
    cmd_valid = v;
    cmd_abs   = a;
    cmd_time  = t;
    cmd_data  = d;
    cmd_keep  = k;
    cmd_last  = l;
  endtask

  task automatic chk_counts();
    chk64("beat_count", 64'(beat_count), 64'(exp_beats));
    chk64("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk64("cycle_count", cycle_count, cyc);
  endtask

  // One quiet cycle after a beat: driver idle, statistics up to date.
  task automatic idle_check();
    @(negedge clk);
    cmd_valid = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    chk64("tvalid_after_beat", 64'(m_axis_tvalid), 64'd0);
    chk_counts();
  endtask

  task automatic idle_until(input longint unsigned k);
    while (cyc + 1 < k) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      m_axis_tready = 1'b0;
    end
  endtask

  // Issue one command from idle and follow it to its handshake. The model only needs the
  // latency rule: relative D -> first valid at N+1+D, absolute T -> max(N+1, T).
  task automatic run_beat(input logic a, input logic [63:0] t, input logic [W_DATA-1:0] d,
                          input logic [W_KEEP-1:0] k, input logic l, input bit rnd_ready);
    longint unsigned n, s;
    bit              hs, exp_v;
    @(negedge clk);
    n = cyc;
    set_cmd(1'b1, a, t, d, k, l);
    m_axis_tready = 1'b0;
    #1;
    chk64("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    chk64("tvalid_before_accept", 64'(m_axis_tvalid), 64'd0);
    if (a) s = (t > n + 1) ? t : n + 1;
    else   s = n + 1 + t;
    hs = 1'b0;
    for (int i = 0; i < 64 && !hs; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_eof = 1'b0;
      m_axis_tready = (!rnd_ready || cyc >= s + 6) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_v = (cyc >= s);
      chk64("tvalid_timing", 64'(m_axis_tvalid), 64'(exp_v));
      chk64("done_while_busy", 64'(done), 64'd0);
      if (exp_v) begin
        chkd("tdata", m_axis_tdata, d);
        chk64("tkeep", m_axis_tkeep, k);
        chk64("tlast", 64'(m_axis_tlast), 64'(l));
        if (m_axis_tready) begin
          hs = 1'b1;
          exp_beats++;
          if (l) exp_pkts++;
        end
      end
    end
    chk64("handshake_timeout", 64'(hs), 64'd1);
  endtask

  initial begin
    logic [W_DATA-1:0] da, db, dc, pat;
    logic [W_KEEP-1:0] ka, kb;
    logic [W_DATA-1:0] bb [3];
    logic              a;
    logic [63:0]       t;

    // Reset state; cmd_ready must stay low even with a command offered.
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    #1;
    chk64("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk64("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chkd("rst_tdata", m_axis_tdata, '0);
    chk64("rst_tkeep", m_axis_tkeep, 64'd0);
    chk64("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk64("rst_done", 64'(done), 64'd0);
    chk_counts();
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk64("cycle0", cycle_count, 64'd0);

    // Relative delay 5 accepted at cycle 10: first valid at 16.
    idle_until(10);
    run_beat(1'b0, 64'd5, rnd_data(), {$urandom, $urandom}, 1'b0, 1'b0);
    idle_check();

    // Absolute 100 accepted at 20; target 50 accepted on the handshake at 101 -> beat at 102.
    da = rnd_data(); db = rnd_data(); ka = {$urandom, $urandom}; kb = {$urandom, $urandom};
    idle_until(20);
    @(negedge clk);
    set_cmd(1'b1, 1'b1, 64'd100, da, ka, 1'b0);
    #1;
    chk64("abs_accept_cycle", cycle_count, 64'd20);
    while (cyc < 99) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk64("abs_wait_tvalid", 64'(m_axis_tvalid), 64'd0);
    end
    @(negedge clk);
    #1;
    chk64("abs_tvalid_100", 64'(m_axis_tvalid), 64'd1);
    chk64("abs_cycle_100", cycle_count, 64'd100);
    chkd("abs_tdata_100", m_axis_tdata, da);
    @(negedge clk);
    m_axis_tready = 1'b1;
    set_cmd(1'b1, 1'b1, 64'd50, db, kb, 1'b1);
    #1;
    chk64("abs_cmd_ready_hs", 64'(cmd_ready), 64'd1);
    chkd("abs_tdata_101", m_axis_tdata, da);
    exp_beats++;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk64("abs_past_tvalid_102", 64'(m_axis_tvalid), 64'd1);
    chk64("abs_cycle_102", cycle_count, 64'd102);
    chkd("abs_past_tdata", m_axis_tdata, db);
    chk64("abs_past_tkeep", m_axis_tkeep, kb);
    exp_beats++;
    exp_pkts++;
    idle_check();

    // Three back-to-back delay-0 beats under tready=1, last on the third.
    for (int i = 0; i < 3; i++) bb[i] = rnd_data();
    @(negedge clk);
    m_axis_tready = 1'b1;
    set_cmd(1'b1, 1'b0, 64'd0, bb[0], '1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) set_cmd(1'b1, 1'b0, 64'd0, bb[i+1], '1, i == 1);
      else       cmd_valid = 1'b0;
      #1;
      chk64("b2b_tvalid", 64'(m_axis_tvalid), 64'd1);
      chkd("b2b_tdata", m_axis_tdata, bb[i]);
      chk64("b2b_tlast", 64'(m_axis_tlast), 64'(i == 2));
    end
    exp_beats += 3;
    exp_pkts++;
    idle_check();

    // Backpressure: payload stays put while tready is low, one handshake only.
    dc = rnd_data();
    @(negedge clk);
    set_cmd(1'b1, 1'b0, 64'd0, dc, ka, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      m_axis_tready = (i == 2);
      #1;
      chk64("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      chkd("bp_tdata", m_axis_tdata, dc);
      chk64("bp_tkeep", m_axis_tkeep, ka);
      chk64("bp_tlast", 64'(m_axis_tlast), 64'd1);
    end
    exp_beats++;
    exp_pkts++;
    idle_check();

    // EOF during a relative wait: done only once the beat is gone and the driver is idle.
    @(negedge clk);
    #1;
    chk64("done_before_eof", 64'(done), 64'd0);
    @(negedge clk);
    m_axis_tready = 1'b1;
    set_cmd(1'b1, 1'b0, 64'd3, da, kb, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_eof = (i == 1);
      #1;
      chk64("eof_tvalid", 64'(m_axis_tvalid), 64'(i == 4));
      if (i <= 4) chk64("eof_done_pending", 64'(done), 64'd0);
      if (i >= 6) chk64("eof_done_sticky", 64'(done), 64'd1);
    end
    exp_beats++;
    chk_counts();

    // Randomized commands after EOF: each must still be processed and clear done meanwhile.
    for (int i = 0; i < 25; i++) begin
      a = 1'($urandom_range(0, 1));
      if (a) t = cyc + 64'($urandom_range(0, 10)) - 2;
      else   t = 64'($urandom_range(0, 7));
      run_beat(a, t, rnd_data(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      idle_check();
    end
    @(negedge clk);
    #1;
    chk64("done_after_random", 64'(done), 64'd1);

    // Reset in the middle of a held beat drops everything immediately.
    pat = {64{8'hA5}};
    @(negedge clk);
    m_axis_tready = 1'b0;
    set_cmd(1'b1, 1'b0, 64'd0, pat, '1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk64("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    chkd("pre_rst_tdata", m_axis_tdata, pat);
    #1;
    rst = 1'b1;
    #1;
    exp_beats = 0;
    exp_pkts = 0;
    chk64("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk64("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk64("mid_rst_done", 64'(done), 64'd0);
    chk_counts();
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk64("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk_counts();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
